// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported RAM; one access in flight, IDLE->ACCESS->RESP.
// Define ARB_FIXED_PRIO_EN to make port 0 win every contention instead of alternating.
module ram_port_arbiter #(
    parameter int datalines = 16,
    parameter int adlines   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 rd0,
    input  logic                 wr0,
    input  logic [adlines-1:0]   addr0,
    input  logic [datalines-1:0] wdata0,
    output logic                 ack0,
    output logic [datalines-1:0] rdata0,
    input  logic                 req1,
    input  logic                 rd1,
    input  logic                 wr1,
    input  logic [adlines-1:0]   addr1,
    input  logic [datalines-1:0] wdata1,
    output logic                 ack1,
    output logic [datalines-1:0] rdata1,
    output logic                 gnt,
    output logic                 busy,
    output logic [adlines-1:0]   addressbus,
    output logic                 read,
    output logic                 write,
    output logic [datalines-1:0] toram,
    input  logic [datalines-1:0] fromram
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                 state, state_nxt;
    logic                   last_gnt, last_gnt_nxt;
    logic                   cmd_rd, cmd_rd_nxt;
    logic                   gnt_nxt, busy_nxt, read_nxt, write_nxt;
    logic                   ack0_nxt, ack1_nxt;
    logic [adlines-1:0]     addr_nxt;
    logic [datalines-1:0]   toram_nxt, rdata0_nxt, rdata1_nxt;
    logic                   cand0, cand1, pick, sel_rd, sel_wr;

    // A port still showing its ack is not a candidate, so it cannot be regranted in its own ack cycle.
    assign cand0 = req0 & ~ack0;
    assign cand1 = req1 & ~ack1;

`ifdef ARB_FIXED_PRIO_EN
    assign pick = ~cand0;
`else
    assign pick = (cand0 & cand1) ? ~last_gnt : cand1;
`endif

    assign sel_rd = pick ? rd1 : rd0;
    assign sel_wr = pick ? wr1 : wr0;

    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        cmd_rd_nxt   = cmd_rd;
        gnt_nxt      = gnt;
        busy_nxt     = busy;
        read_nxt     = 1'b0;
        write_nxt    = 1'b0;
        ack0_nxt     = 1'b0;
        ack1_nxt     = 1'b0;
        addr_nxt     = addressbus;
        toram_nxt    = toram;
        rdata0_nxt   = rdata0;
        rdata1_nxt   = rdata1;
        case (state)
            IDLE: begin
                if (cand0 | cand1) begin
                    gnt_nxt      = pick;
                    last_gnt_nxt = pick;
                    busy_nxt     = 1'b1;
                    addr_nxt     = pick ? addr1 : addr0;
                    toram_nxt    = pick ? wdata1 : wdata0;
                    // Write takes precedence when both command bits are set.
                    write_nxt    = sel_wr;
                    read_nxt     = sel_rd & ~sel_wr;
                    cmd_rd_nxt   = sel_rd & ~sel_wr;
                    state_nxt    = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (cmd_rd) begin
                    if (gnt) rdata1_nxt = fromram;
                    else     rdata0_nxt = fromram;
                end
                ack0_nxt  = ~gnt;
                ack1_nxt  = gnt;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_gnt   <= 1'b1;
            cmd_rd     <= 1'b0;
            gnt        <= 1'b0;
            busy       <= 1'b0;
            read       <= 1'b0;
            write      <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            addressbus <= '0;
            toram      <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            state      <= state_nxt;
            last_gnt   <= last_gnt_nxt;
            cmd_rd     <= cmd_rd_nxt;
            gnt        <= gnt_nxt;
            busy       <= busy_nxt;
            read       <= read_nxt;
            write      <= write_nxt;
            ack0       <= ack0_nxt;
            ack1       <= ack1_nxt;
            addressbus <= addr_nxt;
            toram      <= toram_nxt;
            rdata0     <= rdata0_nxt;
            rdata1     <= rdata1_nxt;
        end
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single RAM port (addressbus, read, write, toram, fromram) between two requesters.
  - Port 0: control unit.
  - Port 1: program loader / IO master.
- Per-port handshake is req/ack. Arbitration is round-robin; one RAM transaction is in flight at a time.
- Sits between the requesters and the RAM. It is the only block that drives the RAM strobes.

Parameters:
- datalines, 16, RAM data width.
- adlines, 8, RAM address width.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  port 0 request; held high with its command until ack0.
- rd0  input  1  port 0 read command.
- wr0  input  1  port 0 write command.
- addr0  input  adlines  port 0 address.
- wdata0  input  datalines  port 0 write data.
- ack0  output  1  port 0 completion pulse, 1 cycle.
- rdata0  output  datalines  port 0 read data; valid while ack0=1, held afterwards.
- req1, rd1, wr1, addr1, wdata1, ack1, rdata1  same as above, for port 1.
- gnt  output  1  index of the port currently owning the RAM; valid while busy=1.
- busy  output  1  a transaction is in progress.
- addressbus  output  adlines  RAM address.
- read  output  1  RAM read strobe.
- write  output  1  RAM write strobe.
- toram  output  datalines  RAM write data.
- fromram  input  datalines  RAM read data; valid the cycle after read is sampled high.

Behaviour:
- All outputs are registered.
- Reset (including mid-transaction):
  - State=IDLE.
  - addressbus, toram, read, write, ack0, ack1, busy, gnt, rdata0 and rdata1 all go to 0.
  - last_gnt=1, so port 0 wins the first contention.
  - An aborted transaction gets no ack; its requester must re-request.
- State machine: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - Candidates are ports with reqN=1 and ackN=0. A port is never regranted in its own ack cycle.
  - No candidate: stay in IDLE with strobes 0.
  - One candidate: grant it.
  - Two candidates: grant the port != last_gnt.
  - On grant:
    - gnt=N, last_gnt=N, busy=1.
    - addressbus=addrN, toram=wdataN.
    - write=wrN; read=rdN & ~wrN (write wins if both are set).
    - Go to ACCESS.
- ACCESS:
  - Clear read and write; address and data are held.
  - Go to RESP.
  - The RAM performs the access during this cycle.
- RESP:
  - If the granted command was a read, rdataN <= fromram. Otherwise rdataN is unchanged.
  - ackN=1 for exactly one cycle.
  - busy=0; go to IDLE.
- Latency: req is sampled at edge E0; the strobe is high E0..E1; ack is high E2..E3.
  - A single uncontended access therefore takes 3 cycles. Back-to-back throughput is 1 access per 3 cycles.
- reqN with rd=wr=0: still arbitrated. No strobe is issued; ack is returned with rdata unchanged.
- Requester inputs are sampled only at the IDLE grant edge. Changes while busy are ignored.
- A requester deasserting req before ack does not abort the transaction; ack is still issued.
- Round-robin guarantee: with both ports requesting continuously, grants alternate 0,1,0,1. Neither port waits more than one transaction.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
  - Defined: port 0 always wins contention and last_gnt is ignored, so port 1 can starve.
  - Undefined: round-robin as above.
- Both builds share the same ports and latency.

Test Plan:
- Reset, then req0 read addr0=8'h10, RAM[10]=16'hBEEF -> read=1 at E0..E1, addressbus=8'h10, ack0 at E2, rdata0=16'hBEEF, busy low after E2.
- req1 write addr1=8'h20, wdata1=16'h1234 -> write=1 for one cycle, toram=16'h1234, ack1 at E2; a follow-up read of 8'h20 returns 16'h1234.
- req0 and req1 held high, 6 transactions -> gnt sequence 0,1,0,1,0,1 and exactly 3 acks per port. With ARB_FIXED_PRIO_EN, all 6 grants go to port 0.
- rd0=wr0=1, addr0=8'h05, wdata0=16'h00AA -> only write=1; RAM[05]=16'h00AA; rdata0 unchanged.
- Reset asserted in ACCESS of a port 1 read -> next cycle read=write=ack1=busy=0, state IDLE; the next contended grant goes to port 0.
- req0 with rd0=wr0=0 -> no strobe; ack0 at E2; rdata0 holds its prior value.
